// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, golden-result function, BIST patterns,
// LFSR polynomials and the BIST FSM state type.
package alu_pkg;

   localparam logic [1:0] ALU_OP_AND = 2'b00;
   localparam logic [1:0] ALU_OP_NOT = 2'b01;
   localparam logic [1:0] ALU_OP_XOR = 2'b10;
   localparam logic [1:0] ALU_OP_OR  = 2'b11;

   localparam logic [7:0] BIST_A_PAT = 8'hCC;
   localparam logic [7:0] BIST_B_PAT = 8'hAA;

   // Right-shifting Galois LFSR polynomials, indexed by the ALU operand width.
   localparam logic [31:0] LFSR_POLY_W8  = 32'h0000_B400;
   localparam logic [31:0] LFSR_POLY_W16 = 32'h8020_0003;

   typedef enum logic [1:0] {
      BIST_IDLE = 2'd0,
      BIST_RUN  = 2'd1,
      BIST_DONE = 2'd2
   } bist_state_e;

   // Golden ALU result at the widest supported width; callers mask to their width.
   function automatic logic [15:0] alu_golden(input logic [15:0] a,
                                              input logic [15:0] b,
                                              input logic [1:0]  op);
      logic [15:0] y;
      case (op)
         ALU_OP_AND: y = a & b;
         ALU_OP_NOT: y = ~a;
         ALU_OP_XOR: y = a ^ b;
         default:    y = a | b;
      endcase
      return y;
   endfunction

   function automatic logic [31:0] lfsr_poly(input int unsigned width);
      return (width == 16) ? LFSR_POLY_W16 : LFSR_POLY_W8;
   endfunction

endpackage

// File: rtl/alu_bist_if.sv
// ALU operand/result bus between the BIST engine (master) and the ALU (slave).
// The ALU answers combinationally on y within the same clock period.
interface alu_bist_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic [WIDTH-1:0] y;

   modport master (output a, output b, output op, input y);
   modport slave  (input a, input b, input op, output y);
endinterface

// File: rtl/alu_bist_lfsr.sv
// Galois LFSR used by the BIST random phase; load has priority over step.
// A zero seed is replaced by 1 so the register can never lock up.
module alu_bist_lfsr #(
   parameter int unsigned   W    = 16,
   parameter logic [W-1:0]  POLY = '0,
   parameter logic [W-1:0]  SEED = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         step_i,
   output logic [W-1:0] state_o
);

   localparam logic [W-1:0] SEED_NZ = (SEED == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED;

   logic [W-1:0] lfsr_q;
   logic [W-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SEED_NZ;
      end else if (step_i) begin
         lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED_NZ;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/alu_bist.sv
// alu_bist: self-test engine that drives vectors into the ALU and checks Y.
// Defining ALU_BIST_LFSR_EN adds NUM_VECTORS pseudo-random vectors after the 4 directed ones.
module alu_bist
   import alu_pkg::*;
#(
   parameter int unsigned        WIDTH       = 8,
   parameter int unsigned        NUM_VECTORS = 256,
   parameter logic [2*WIDTH-1:0] SEED        = 16'hACE1,
   parameter int unsigned        ERR_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   // start is a level request sampled only in IDLE/DONE; there is no ready,
   // so a start seen while busy is simply dropped.
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   alu_bist_if.master        alu,
   output logic [ERR_W-1:0]  err_cnt,
   output logic              fail_valid,
   output logic [1:0]        fail_op,
   output logic [WIDTH-1:0]  fail_y,
   output bist_state_e       dbg_state
);

   if (!(WIDTH == 8 || WIDTH == 16) || NUM_VECTORS < 1 || ERR_W < 1 ||
       $bits(SEED) != 2 * WIDTH) begin : g_bad_param
      $error("alu_bist: unsupported parameter set");
   end

`ifdef ALU_BIST_LFSR_EN
   localparam int unsigned RUN_LEN = 4 + NUM_VECTORS;
`else
   localparam int unsigned RUN_LEN = 4;
`endif
   localparam int unsigned        IDX_W    = $clog2(RUN_LEN);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(RUN_LEN - 1);
   localparam logic [WIDTH-1:0]   DIR_A    = {(WIDTH/8){BIST_A_PAT}};
   localparam logic [WIDTH-1:0]   DIR_B    = {(WIDTH/8){BIST_B_PAT}};
   localparam logic [15:0]        CMP_MASK = 16'((32'd1 << WIDTH) - 32'd1);

   bist_state_e        state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [1:0]         op_q, op_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               fail_valid_q, fail_valid_d;
   logic [1:0]         fail_op_q, fail_op_d;
   logic [WIDTH-1:0]   fail_y_q, fail_y_d;
   logic               done_q, done_d;

   logic [15:0]        a_ext, b_ext, y_ext, gold_ext;
   logic               mismatch;

`ifdef ALU_BIST_LFSR_EN
   localparam logic [31:0] POLY_FULL = lfsr_poly(WIDTH);

   logic               lfsr_load;
   logic               lfsr_step;
   logic [2*WIDTH-1:0] lfsr_state;

   alu_bist_lfsr #(
      .W    (2 * WIDTH),
      .POLY (POLY_FULL[2*WIDTH-1:0]),
      .SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load_i  (lfsr_load),
      .step_i  (lfsr_step),
      .state_o (lfsr_state)
   );
`endif

   // Golden is evaluated on the vector currently driven, so the compare at each
   // RUN edge checks the result the ALU settled on during the previous cycle.
   always_comb begin
      a_ext = '0;
      b_ext = '0;
      y_ext = '0;
      a_ext[WIDTH-1:0] = a_q;
      b_ext[WIDTH-1:0] = b_q;
      y_ext[WIDTH-1:0] = alu.y;
      gold_ext = alu_golden(a_ext, b_ext, op_q);
      mismatch = ((gold_ext ^ y_ext) & CMP_MASK) != '0;
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      fail_op_d    = fail_op_q;
      fail_y_d     = fail_y_q;
      done_d       = done_q;
`ifdef ALU_BIST_LFSR_EN
      lfsr_load    = 1'b0;
      lfsr_step    = 1'b0;
`endif
      case (state_q)
         BIST_IDLE, BIST_DONE: begin
            if (start) begin
               state_d      = BIST_RUN;
               idx_d        = '0;
               a_d          = DIR_A;
               b_d          = DIR_B;
               op_d         = ALU_OP_AND;
               err_d        = '0;
               fail_valid_d = 1'b0;
               fail_op_d    = '0;
               fail_y_d     = '0;
               done_d       = 1'b0;
`ifdef ALU_BIST_LFSR_EN
               lfsr_load    = 1'b1;
`endif
            end
         end
         BIST_RUN: begin
            if (mismatch) begin
               if (err_q != '1) begin
                  err_d = err_q + 1'b1;
               end
               if (!fail_valid_q) begin
                  fail_valid_d = 1'b1;
                  fail_op_d    = op_q;
                  fail_y_d     = alu.y;
               end
            end
            if (idx_q == LAST_IDX) begin
               state_d = BIST_DONE;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
               op_d  = idx_d[1:0];
`ifdef ALU_BIST_LFSR_EN
               // Past the directed vectors: take A/B from the LFSR, then advance it.
               if (idx_d[IDX_W-1:2] != '0) begin
                  a_d       = lfsr_state[2*WIDTH-1:WIDTH];
                  b_d       = lfsr_state[WIDTH-1:0];
                  lfsr_step = 1'b1;
               end
`endif
            end
         end
         default: state_d = BIST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= BIST_IDLE;
         idx_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         fail_op_q    <= '0;
         fail_y_q     <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         fail_op_q    <= fail_op_d;
         fail_y_q     <= fail_y_d;
         done_q       <= done_d;
      end
   end

   assign busy       = (state_q == BIST_RUN);
   assign done       = done_q;
   assign pass       = done_q && (err_q == '0);
   assign alu.a      = a_q;
   assign alu.b      = b_q;
   assign alu.op     = op_q;
   assign err_cnt    = err_q;
   assign fail_valid = fail_valid_q;
   assign fail_op    = fail_op_q;
   assign fail_y     = fail_y_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a fault-injectable ALU model feeds Y back, and a vector-list
// reference model predicts the driven sequence, error count and first failure.
module tb_alu_bist;
   import alu_pkg::*;

   localparam int W  = 8;
   localparam int EW = 2;
   localparam int NV = 16;
`ifdef ALU_BIST_LFSR_EN
   localparam int RUN_LEN = 4 + NV;
`else
   localparam int RUN_LEN = 4;
`endif
   localparam int ERR_MAX = (1 << EW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy, done, pass, fail_valid;
   logic [EW-1:0] err_cnt;
   logic [1:0]    fail_op;
   logic [W-1:0]  fail_y;
   bist_state_e   dbg_state;

   logic [W-1:0]  or_mask  [4];
   logic [W-1:0]  xor_mask [4];

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] exp_a_q[$];
   logic [W-1:0] exp_b_q[$];
   logic [1:0]   exp_op_q[$];

   logic [W-1:0] obs_a[$];
   logic [W-1:0] obs_b[$];
   logic [1:0]   obs_op[$];
   logic         obs_busy[$];
   logic         obs_done[$];
   logic         f_done, f_busy, f_pass, f_fv;
   logic [EW-1:0] f_err;
   logic [1:0]   f_fop;
   logic [W-1:0] f_fy;

   alu_bist_if #(.WIDTH(W)) alu_if ();

   alu_bist #(
      .WIDTH       (W),
      .NUM_VECTORS (NV),
      .SEED        (16'hACE1),
      .ERR_W       (EW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .alu        (alu_if),
      .err_cnt    (err_cnt),
      .fail_valid (fail_valid),
      .fail_op    (fail_op),
      .fail_y     (fail_y),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
      case (op)
         2'd0:    return a & b;
         2'd1:    return ~a;
         2'd2:    return a ^ b;
         default: return a | b;
      endcase
   endfunction

   // ALU under test: correct result with per-opcode stuck-at-1 and flip masks.
   always_comb alu_if.y = (ref_alu(alu_if.a, alu_if.b, alu_if.op) | or_mask[alu_if.op])
                          ^ xor_mask[alu_if.op];

   task automatic clear_faults();
      for (int i = 0; i < 4; i++) begin
         or_mask[i]  = '0;
         xor_mask[i] = '0;
      end
   endtask

   task automatic build_vectors();
      logic [2*W-1:0] s;
      exp_a_q.delete();
      exp_b_q.delete();
      exp_op_q.delete();
      for (int k = 0; k < 4; k++) begin
         exp_a_q.push_back(8'hCC);
         exp_b_q.push_back(8'hAA);
         exp_op_q.push_back(2'(k));
      end
`ifdef ALU_BIST_LFSR_EN
      s = 16'hACE1;
      for (int j = 0; j < NV; j++) begin
         exp_a_q.push_back(s[15:8]);
         exp_b_q.push_back(s[7:0]);
         exp_op_q.push_back(2'(j));
         s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
      end
`endif
   endtask

   task automatic model_run(output int errs, output logic fv, output logic [1:0] fop,
                            output logic [W-1:0] fy);
      errs = 0;
      fv   = 1'b0;
      fop  = '0;
      fy   = '0;
      for (int k = 0; k < exp_a_q.size(); k++) begin
         logic [W-1:0] g, y;
         g = ref_alu(exp_a_q[k], exp_b_q[k], exp_op_q[k]);
         y = (g | or_mask[exp_op_q[k]]) ^ xor_mask[exp_op_q[k]];
         if (y !== g) begin
            errs++;
            if (!fv) begin
               fv  = 1'b1;
               fop = exp_op_q[k];
               fy  = y;
            end
         end
      end
      if (errs > ERR_MAX) errs = ERR_MAX;
   endtask

   // One start pulse, then record the bus each cycle and the outputs when done should be up.
   task automatic drive_run();
      obs_a.delete(); obs_b.delete(); obs_op.delete(); obs_busy.delete(); obs_done.delete();
      @(negedge clk); start = 1'b1;
      @(posedge clk); @(negedge clk); start = 1'b0;
      for (int k = 0; k < RUN_LEN; k++) begin
         obs_a.push_back(alu_if.a);
         obs_b.push_back(alu_if.b);
         obs_op.push_back(alu_if.op);
         obs_busy.push_back(busy);
         obs_done.push_back(done);
         @(posedge clk); @(negedge clk);
      end
      f_done = done; f_busy = busy; f_pass = pass; f_fv = fail_valid;
      f_err  = err_cnt; f_fop = fail_op; f_fy = fail_y;
   endtask

   task automatic test_reset();
      clear_faults();
      rst = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done, pass, fail_valid} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_ctrl: busy/done/pass/fail_valid=%b required 0000",
                  {busy, done, pass, fail_valid});
      end
      n_cmp++;
      if ({err_cnt, fail_op, fail_y} !== '0) begin
         n_bad++;
         $display("FAIL reset_result: err_cnt=%0d fail_op=%0d fail_y=%h required all 0",
                  err_cnt, fail_op, fail_y);
      end
      n_cmp++;
      if ({alu_if.a, alu_if.b, alu_if.op} !== '0 || dbg_state !== BIST_IDLE) begin
         n_bad++;
         $display("FAIL reset_bus: a=%h b=%h op=%0d state=%0d required 0/0/0/IDLE",
                  alu_if.a, alu_if.b, alu_if.op, dbg_state);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      clear_faults();
      drive_run();
      for (int k = 0; k < RUN_LEN; k++) begin
         n_cmp++;
         if ({obs_a[k], obs_b[k], obs_op[k], obs_busy[k], obs_done[k]} !==
             {exp_a_q[k], exp_b_q[k], exp_op_q[k], 2'b10}) begin
            n_bad++;
            $display("FAIL directed_vec%0d: a=%h b=%h op=%0d busy=%b done=%b required a=%h b=%h op=%0d busy=1 done=0",
                     k, obs_a[k], obs_b[k], obs_op[k], obs_busy[k], obs_done[k],
                     exp_a_q[k], exp_b_q[k], exp_op_q[k]);
         end
      end
      n_cmp++;
      if ({f_done, f_busy, f_pass, f_fv, f_err} !== {4'b1010, {EW{1'b0}}}) begin
         n_bad++;
         $display("FAIL directed_final: done=%b busy=%b pass=%b fail_valid=%b err_cnt=%0d required 1/0/1/0/0",
                  f_done, f_busy, f_pass, f_fv, f_err);
      end
   endtask

   task automatic test_stuck_xor();
      int errs; logic fv; logic [1:0] fop; logic [W-1:0] fy;
      clear_faults();
      or_mask[2] = 8'h01;
      model_run(errs, fv, fop, fy);
      drive_run();
      n_cmp++;
      if ({f_fv, f_fop, f_fy} !== {1'b1, 2'b10, 8'h67}) begin
         n_bad++;
         $display("FAIL stuck_xor_capture: fail_valid=%b fail_op=%0d fail_y=%h required 1/2/67",
                  f_fv, f_fop, f_fy);
      end
      n_cmp++;
      if (f_err !== EW'(errs) || f_pass !== 1'b0 || f_done !== 1'b1) begin
         n_bad++;
         $display("FAIL stuck_xor_count: err_cnt=%0d pass=%b done=%b required %0d/0/1",
                  f_err, f_pass, f_done, errs);
      end
   endtask

   task automatic test_saturate();
      clear_faults();
      for (int i = 0; i < 4; i++) xor_mask[i] = '1;
      drive_run();
      n_cmp++;
      if (f_err !== EW'(ERR_MAX)) begin
         n_bad++;
         $display("FAIL saturate_count: err_cnt=%0d required %0d", f_err, ERR_MAX);
      end
      n_cmp++;
      if ({f_fv, f_fop, f_fy, f_pass} !== {1'b1, 2'b00, 8'h77, 1'b0}) begin
         n_bad++;
         $display("FAIL saturate_capture: fail_valid=%b fail_op=%0d fail_y=%h pass=%b required 1/0/77/0",
                  f_fv, f_fop, f_fy, f_pass);
      end
   endtask

   task automatic test_start_held();
      int errs; logic fv; logic [1:0] fop; logic [W-1:0] fy;
      clear_faults();
      xor_mask[1] = 8'h0F;
      model_run(errs, fv, fop, fy);
      @(negedge clk); start = 1'b1;
      @(posedge clk); @(negedge clk);
      for (int k = 0; k < RUN_LEN; k++) begin
         n_cmp++;
         if (busy !== 1'b1 || alu_if.op !== exp_op_q[k] || alu_if.a !== exp_a_q[k]) begin
            n_bad++;
            $display("FAIL held_vec%0d: busy=%b op=%0d a=%h required busy=1 op=%0d a=%h",
                     k, busy, alu_if.op, alu_if.a, exp_op_q[k], exp_a_q[k]);
         end
         @(posedge clk); @(negedge clk);
      end
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || err_cnt !== EW'(errs)) begin
         n_bad++;
         $display("FAIL held_first_done: done=%b busy=%b err_cnt=%0d required 1/0/%0d",
                  done, busy, err_cnt, errs);
      end
      clear_faults();
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if ({busy, done, err_cnt, fail_valid, alu_if.op} !== {2'b10, {EW{1'b0}}, 1'b0, 2'b00}) begin
         n_bad++;
         $display("FAIL held_restart: busy=%b done=%b err_cnt=%0d fail_valid=%b op=%0d required 1/0/0/0/0",
                  busy, done, err_cnt, fail_valid, alu_if.op);
      end
      start = 1'b0;
      for (int k = 0; k < RUN_LEN; k++) begin
         @(posedge clk); @(negedge clk);
      end
      n_cmp++;
      if ({done, pass, fail_valid, err_cnt} !== {3'b110, {EW{1'b0}}}) begin
         n_bad++;
         $display("FAIL held_second_run: done=%b pass=%b fail_valid=%b err_cnt=%0d required 1/1/0/0",
                  done, pass, fail_valid, err_cnt);
      end
   endtask

   task automatic test_async_reset();
      clear_faults();
      xor_mask[0] = '1;
      @(negedge clk); start = 1'b1;
      @(posedge clk); @(negedge clk); start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, pass, fail_valid, err_cnt, fail_op, fail_y} !== '0) begin
         n_bad++;
         $display("FAIL async_rst_status: busy=%b done=%b pass=%b fail_valid=%b err_cnt=%0d fail_op=%0d fail_y=%h required all 0",
                  busy, done, pass, fail_valid, err_cnt, fail_op, fail_y);
      end
      n_cmp++;
      if ({alu_if.a, alu_if.b, alu_if.op} !== '0 || dbg_state !== BIST_IDLE) begin
         n_bad++;
         $display("FAIL async_rst_bus: a=%h b=%h op=%0d state=%0d required 0/0/0/IDLE",
                  alu_if.a, alu_if.b, alu_if.op, dbg_state);
      end
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== BIST_IDLE || alu_if.a !== '0) begin
         n_bad++;
         $display("FAIL async_rst_idle: busy=%b done=%b state=%0d a=%h required 0/0/IDLE/0",
                  busy, done, dbg_state, alu_if.a);
      end
   endtask

   task automatic test_random();
      int errs; logic fv; logic [1:0] fop; logic [W-1:0] fy;
      for (int it = 0; it < 6; it++) begin
         clear_faults();
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) xor_mask[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) or_mask[i]  = 8'($urandom_range(0, 255));
         end
         model_run(errs, fv, fop, fy);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         drive_run();
         for (int k = 0; k < RUN_LEN; k++) begin
            n_cmp++;
            if ({obs_a[k], obs_b[k], obs_op[k], obs_busy[k], obs_done[k]} !==
                {exp_a_q[k], exp_b_q[k], exp_op_q[k], 2'b10}) begin
               n_bad++;
               $display("FAIL random%0d_vec%0d: a=%h b=%h op=%0d busy=%b done=%b required a=%h b=%h op=%0d busy=1 done=0",
                        it, k, obs_a[k], obs_b[k], obs_op[k], obs_busy[k], obs_done[k],
                        exp_a_q[k], exp_b_q[k], exp_op_q[k]);
            end
         end
         n_cmp++;
         if ({f_done, f_busy, f_err, f_fv, f_fop, f_fy, f_pass} !==
             {2'b10, EW'(errs), fv, fop, fy, (errs == 0)}) begin
            n_bad++;
            $display("FAIL random%0d_final: done=%b busy=%b err=%0d fv=%b fop=%0d fy=%h pass=%b required 1/0/%0d/%b/%0d/%h/%b",
                     it, f_done, f_busy, f_err, f_fv, f_fop, f_fy, f_pass,
                     errs, fv, fop, fy, (errs == 0));
         end
      end
   endtask

`ifdef ALU_BIST_LFSR_EN
   task automatic test_lfsr_repeat();
      logic [W-1:0] first_a[$];
      logic [W-1:0] first_b[$];
      clear_faults();
      drive_run();
      first_a = obs_a;
      first_b = obs_b;
      n_cmp++;
      if (obs_a[4] !== 8'hAC || obs_b[4] !== 8'hE1) begin
         n_bad++;
         $display("FAIL lfsr_first_vec: a=%h b=%h required AC/E1", obs_a[4], obs_b[4]);
      end
      n_cmp++;
      if (f_done !== 1'b1 || f_pass !== 1'b1 || obs_done[RUN_LEN-1] !== 1'b0) begin
         n_bad++;
         $display("FAIL lfsr_done_time: done=%b pass=%b done_one_early=%b required 1/1/0",
                  f_done, f_pass, obs_done[RUN_LEN-1]);
      end
      drive_run();
      for (int k = 0; k < RUN_LEN; k++) begin
         n_cmp++;
         if (obs_a[k] !== first_a[k] || obs_b[k] !== first_b[k]) begin
            n_bad++;
            $display("FAIL lfsr_repeat_vec%0d: a=%h b=%h required a=%h b=%h",
                     k, obs_a[k], obs_b[k], first_a[k], first_b[k]);
         end
      end
   endtask
`endif

   initial begin
      build_vectors();
      test_reset();
      test_directed();
      test_stuck_xor();
      test_saturate();
      test_start_held();
      test_async_reset();
      test_random();
`ifdef ALU_BIST_LFSR_EN
      test_lfsr_repeat();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test engine for the 8-bit ALU (opcode 00 AND, 01 NOT A, 10 XOR, 11 OR). It is the hardware counterpart of the bench-side ALU checker. On a start pulse it drives operand/opcode vectors into the ALU's A/B/opcode inputs and samples Y. It compares each result against an internally computed golden value, then reports an error count, the first failing result and a pass flag. It sits beside the ALU in the datapath and is muxed onto the ALU inputs by the integrator while `busy` is high.

## Interface
- `WIDTH`, 8: operand/result width; 8 or 16 only.
- `NUM_VECTORS`, 256: pseudo-random vectors per run (only with `ALU_BIST_LFSR_EN`); ≥1.
- `SEED`, 16'hACE1: LFSR seed, 2*WIDTH bits; 0 is replaced by 1.
- `ERR_W`, 16: error counter width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  run request, sampled in IDLE/DONE.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished, held until next start.
- `pass`  out  1  done && err_cnt==0.
- `alu_a`  out  WIDTH  ALU operand A.
- `alu_b`  out  WIDTH  ALU operand B.
- `alu_op`  out  2  ALU opcode.
- `alu_y`  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- `err_cnt`  out  ERR_W  mismatch count, saturating.
- `fail_valid`  out  1  a mismatch has been captured this run.
- `fail_op`  out  2  opcode of first mismatch.
- `fail_y`  out  WIDTH  alu_y of first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --last vector compared--> DONE.
  - DONE --start--> RUN.
- Reset values: every output is 0. FSM goes to IDLE and the LFSR loads SEED.
- On entry to RUN:
  - clear err_cnt, fail_*, done.
  - reload LFSR with SEED.
  - load vector 0 onto alu_*.
- Every RUN edge:
  - compare alu_y with golden(alu_a, alu_b, alu_op).
  - on mismatch, increment err_cnt (saturates at all-ones). If fail_valid=0, capture fail_op/fail_y and set fail_valid.
  - load the next vector, or go to DONE after the last vector.
- Golden values:
  - AND = a&b
  - NOT = ~a (b ignored)
  - XOR = a^b
  - OR = a|b
- Directed phase, vectors 0..3: A = {WIDTH/8{8'hCC}}, B = {WIDTH/8{8'hAA}}, op = 00, 01, 10, 11. For WIDTH=8 the expected results are 88, 33, 66, EE.
- Random phase (only with `ALU_BIST_LFSR_EN`), vector j = 0..NUM_VECTORS-1:
  - op = j[1:0]
  - A = lfsr[2W-1:W]
  - B = lfsr[W-1:0]
  - the LFSR advances one step after each random vector is loaded.
  - the first random vector uses the SEED state.
- `start` while busy: ignored. `start` held high is level-sensitive only in IDLE/DONE, so holding it across DONE immediately re-runs.
- alu_* hold their last vector in DONE and return to 0 only on reset.

## Timing
- 1 vector per cycle; the ALU is assumed to settle within one clock period.
- Start accepted at edge E0. busy=1 and vector 0 are driven from E0 onward.
- done=1 from edge E0+N, where N=4 without the macro and N=4+NUM_VECTORS with it. busy falls at the same edge.
- pass, err_cnt and fail_* are final when done rises.
- Async rst mid-run: outputs go to 0 without a clock edge. The run is abandoned and there is no partial done.

## Configuration
- `ALU_BIST_LFSR_EN` defined: the LFSR and random phase are compiled in; run length is 4+NUM_VECTORS.
- Not defined: no LFSR logic; only the 4 directed vectors run. `SEED` and `NUM_VECTORS` are unused.

## Structure
- Package `alu_pkg` holds:
  - opcode constants `ALU_OP_AND/NOT/XOR/OR` and the golden-result function.
  - the directed operand constants `BIST_A_PAT`=CC, `BIST_B_PAT`=AA.
  - LFSR polynomials per width: Galois 16'hB400 (WIDTH=8), 32'h80200003 (WIDTH=16).
- Sub-module `alu_bist_lfsr` (width 2*WIDTH, load/step ports) is instantiated only under the macro.

## Test plan
- Correct ALU, macro off: reset, 1-cycle start → alu_* shows CC/AA/00, CC/AA/01, CC/AA/10, CC/AA/11 on consecutive cycles. done at E0+4, err_cnt=0, pass=1, fail_valid=0.
- ALU with Y[0] stuck-1 on XOR only → err_cnt=1, fail_op=10, fail_y=67, fail_valid=1, pass=0.
- start held high through a run → no effect while busy, restart at the first DONE cycle. A second run clears err_cnt and fail_*.
- rst asserted between clock edges in cycle 2 of a run → all outputs 0 immediately. IDLE persists until start.
- Macro on, NUM_VECTORS=16, correct ALU → done at E0+20, pass=1. Two runs produce identical alu_* sequences. The first random vector has A=AC, B=E1.
- Macro on, ERR_W=2, ALU returning ~golden → err_cnt saturates at 3. fail_op=00, fail_y=77.
